// File: rtl/mmio_pkg.sv
// Shared register-map offsets, RV32 access-width codes and bus lane helpers
// for the memory-mapped PWM/timebase peripheral.
package mmio_pkg;

    localparam logic [3:0] DUTY_OFF   = 4'h0;
    localparam logic [3:0] CTRL_OFF   = 4'h4;
    localparam logic [3:0] MICROS_OFF = 4'h8;
    localparam logic [3:0] MILLIS_OFF = 4'hC;

    localparam logic [2:0] F3_B = 3'b000;
    localparam logic [2:0] F3_H = 3'b001;
    localparam logic [2:0] F3_W = 3'b010;

    localparam int NUM_CH = 4;

    typedef logic [7:0] duty_t;

    // Byte strobe for a store; misaligned halfword/word stores yield no strobe at all.
    function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (funct3)
            F3_B:    be = 4'b0001 << addr_lo;
            F3_H:    if (!addr_lo[0]) be = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    if (addr_lo == 2'b00) be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // The core right-aligns store data; replicate it so every lane sees it.
    function automatic logic [31:0] lane_data(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3)
            F3_B:    return {4{wdata[7:0]}};
            F3_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: duty is shadowed at the period boundary so a mid-period
// write never produces a runt or stretched pulse.
module pwm_channel
    import mmio_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  duty_t pwm_cnt,
    input  logic  period_load,
    input  logic  enable,
    input  duty_t duty,
    output logic  pwm_out
);

    duty_t shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (period_load) shadow <= duty;
            pwm_out <= enable && (pwm_cnt < shadow);
        end
    end

endmodule

// File: rtl/mmio_pwm_timer.sv
// Memory-mapped peripheral: four PWM duty registers, a control register and
// free-running microsecond/millisecond counters in a 16-byte window.
module mmio_pwm_timer
    import mmio_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 12_000_000,
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_FFF0,
    parameter int unsigned PWM_PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_wen,
    input  logic        mem_ren,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_hit,
    output logic        LED,
    output logic        RGB_R,
    output logic        RGB_G,
    output logic        RGB_B
);

    localparam int unsigned TICKS  = CLK_HZ / 1_000_000;
    localparam int unsigned TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS - 1);

    logic        in_window;
    logic [3:0]  reg_off;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic        wr_duty;
    logic        wr_ctrl;
    logic [31:0] rd_word;

    logic [31:0]               duty;
    logic                      ctrl_enable;
    logic [PWM_PRESCALE_W-1:0] ctrl_prescale;

    logic [TICK_W-1:0] tick_cnt;
    logic [9:0]        us_sub;
    logic [31:0]       micros;
    logic [31:0]       millis;
    logic              us_tick;
    logic              ms_tick;

    logic [PWM_PRESCALE_W-1:0] pre_cnt;
    logic [PWM_PRESCALE_W-1:0] pre_active;
    duty_t                     pwm_cnt;
    logic                      pwm_step;
    logic                      period_load;
    logic [NUM_CH-1:0]         pwm_out;

    assign in_window = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_off   = {mem_addr[3:2], 2'b00};
    assign be        = byte_enable(mem_funct3, mem_addr[1:0]);
    assign wlane     = lane_data(mem_funct3, mem_wdata);
    assign wr_duty   = mem_wen && in_window && (reg_off == DUTY_OFF);
    assign wr_ctrl   = mem_wen && in_window && (reg_off == CTRL_OFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty          <= '0;
            ctrl_enable   <= 1'b1;
            ctrl_prescale <= '0;
        end else begin
            // NOTE: non-blocking everywhere in clocked logic, so every flop samples pre-edge values.
            for (int i = 0; i < 4; i++) begin
                if (wr_duty && be[i]) duty[8*i +: 8] <= wlane[8*i +: 8];
            end
            if (wr_ctrl && be[0]) ctrl_enable   <= wlane[0];
            if (wr_ctrl && be[1]) ctrl_prescale <= wlane[8 +: PWM_PRESCALE_W];
        end
    end

    always_comb begin
        // NOTE: default before the case so no path leaves rd_word unassigned (no latch).
        rd_word = '0;
        case (reg_off)
            DUTY_OFF:   rd_word = duty;
            CTRL_OFF: begin
                rd_word[0]                    = ctrl_enable;
                rd_word[8 +: PWM_PRESCALE_W]  = ctrl_prescale;
            end
            MICROS_OFF: rd_word = micros;
            MILLIS_OFF: rd_word = millis;
            default:    rd_word = '0;
        endcase
    end

    // Read data is taken from pre-edge state, so a same-cycle store is not visible yet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rdata <= '0;
            mem_hit   <= 1'b0;
        end else begin
            mem_hit <= (mem_wen || mem_ren) && in_window;
            if (mem_ren) mem_rdata <= in_window ? rd_word : '0;
        end
    end

    assign us_tick = (tick_cnt == TICK_MAX);
    assign ms_tick = us_tick && (us_sub == 10'd999);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            us_sub   <= '0;
            micros   <= '0;
            millis   <= '0;
        end else begin
            tick_cnt <= us_tick ? '0 : tick_cnt + 1'b1;
            if (us_tick) begin
                micros <= micros + 32'd1;
                us_sub <= ms_tick ? '0 : us_sub + 10'd1;
            end
            if (ms_tick) millis <= millis + 32'd1;
        end
    end

    // The active prescale is latched only at a prescale wrap so a write never truncates a step.
    assign pwm_step    = (pre_cnt == pre_active);
    assign period_load = pwm_step && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt    <= '0;
            pre_active <= '0;
            pwm_cnt    <= '0;
        end else if (pwm_step) begin
            pre_cnt    <= '0;
            pre_active <= ctrl_prescale;
            pwm_cnt    <= pwm_cnt + 8'd1;
        end else begin
            pre_cnt    <= pre_cnt + 1'b1;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        pwm_channel u_ch (
            .clk         (clk),
            .reset       (reset),
            .pwm_cnt     (pwm_cnt),
            .period_load (period_load),
            .enable      (ctrl_enable),
            .duty        (duty[8*ch +: 8]),
            .pwm_out     (pwm_out[ch])
        );
    end

    assign LED   = pwm_out[0];
    assign RGB_R = pwm_out[1];
    assign RGB_G = pwm_out[2];
    assign RGB_B = pwm_out[3];

endmodule

// File: tb/tb_mmio_pwm_timer.sv
// Directed self-checking bench for mmio_pwm_timer: register access, PWM
// waveform shape and shadowing, prescale, timebase and asynchronous reset.
module tb_mmio_pwm_timer;
    import mmio_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr = '0;
    logic        mem_wen = 1'b0;
    logic        mem_ren = 1'b0;
    logic [2:0]  mem_funct3 = F3_W;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_hit;
    logic        LED, RGB_R, RGB_G, RGB_B;
    logic [3:0]  pins;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mmio_pwm_timer dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_funct3 (mem_funct3),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_hit    (mem_hit),
        .LED        (LED),
        .RGB_R      (RGB_R),
        .RGB_G      (RGB_G),
        .RGB_B      (RGB_B)
    );

    assign pins = {LED, RGB_R, RGB_G, RGB_B};

    always #5 clk = ~clk;

    // Posedges since the last reset release; at a negedge it equals edges elapsed.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
        mem_addr   = addr;
        mem_funct3 = f3;
        mem_wdata  = data;
        mem_wen    = 1'b1;
        @(negedge clk);
        mem_wen    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic hit);
        mem_addr   = addr;
        mem_funct3 = F3_W;
        mem_ren    = 1'b1;
        @(negedge clk);
        mem_ren    = 1'b0;
        data       = mem_rdata;
        hit        = mem_hit;
    endtask

    task automatic count_high(input int n, output int led, output int r, output int g, output int b);
        led = 0; r = 0; g = 0; b = 0;
        for (int i = 0; i < n; i++) begin
            led += int'(LED);
            r   += int'(RGB_R);
            g   += int'(RGB_G);
            b   += int'(RGB_B);
            @(negedge clk);
        end
    endtask

    task automatic wait_led(input logic level, input int budget, output int waited);
        waited = 0;
        while (LED !== level && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        hit;
        int          c_led, c_r, c_g, c_b;
        int          waited, hi_len, lo_len, snap;

        // Reset and initial register state.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_hit", 32'(mem_hit), 32'h0);
        check("reset_pins", 32'(pins), 32'h0);
        bus_read(BASE + 32'h4, rd, hit);
        check("reset_ctrl", rd, 32'h0000_0001);
        check("ctrl_hit", 32'(hit), 32'h1);
        bus_read(BASE, rd, hit);
        check("reset_duty", rd, 32'h0);

        // Duty write; shadow stays 0 until the first 255->0 wrap at edge 256.
        bus_write(BASE, F3_W, 32'h00FF_8040);
        bus_read(BASE, rd, hit);
        check("duty_sw", rd, 32'h00FF_8040);
        wait_cyc(200);
        check("pins_before_wrap", 32'(pins), 32'h0);
        wait_cyc(256);
        check("pins_cnt255_old", 32'(pins), 32'h0);
        wait_cyc(257);
        check("pins_cnt0_new", 32'(pins), 32'b1110);
        wait_cyc(320);
        check("led_cnt63", 32'(LED), 32'h1);
        wait_cyc(321);
        check("led_cnt64", 32'(LED), 32'h0);
        wait_cyc(512);
        check("pins_cnt255", 32'(pins), 32'h0);
        wait_cyc(513);
        check("pins_period256", 32'(pins), 32'b1110);
        wait_cyc(600);
        count_high(256, c_led, c_r, c_g, c_b);
        check("led_high_64", c_led, 64);
        check("r_high_128", c_r, 128);
        check("g_high_255", c_g, 255);
        check("b_high_0", c_b, 0);

        // Byte/half stores, holds, window decode, simultaneous read/write.
        wait_cyc(900);
        bus_write(BASE + 32'h2, F3_B, 32'h0000_00AA);
        bus_read(BASE, rd, hit);
        check("sb_lane2", rd, 32'h00AA_8040);
        check("sb_hit", 32'(hit), 32'h1);
        @(negedge clk);
        check("rdata_hold", mem_rdata, 32'h00AA_8040);
        check("hit_idle", 32'(mem_hit), 32'h0);
        bus_write(BASE + 32'h1, F3_H, 32'h0000_1234);
        bus_read(BASE, rd, hit);
        check("sh_misaligned", rd, 32'h00AA_8040);
        bus_read(32'hFFFF_FFEC, rd, hit);
        check("oow_rdata", rd, 32'h0);
        check("oow_hit", 32'(hit), 32'h0);
        bus_write(32'hFFFF_FFE0, F3_W, 32'h1234_5678);
        bus_read(BASE, rd, hit);
        check("oow_write", rd, 32'h00AA_8040);
        mem_addr   = BASE;
        mem_funct3 = F3_W;
        mem_wdata  = 32'h1122_3344;
        mem_wen    = 1'b1;
        mem_ren    = 1'b1;
        @(negedge clk);
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        check("rw_read_old", mem_rdata, 32'h00AA_8040);
        check("rw_hit", 32'(mem_hit), 32'h1);
        bus_read(BASE, rd, hit);
        check("rw_write_new", rd, 32'h1122_3344);

        // Timebase: 12 clk per microsecond, 1000 microseconds per millisecond.
        wait_cyc(12000);
        bus_read(BASE + 32'h8, rd, hit);
        check("micros_1000", rd, 32'd1000);
        bus_read(BASE + 32'hC, rd, hit);
        check("millis_1", rd, 32'd1);
        bus_write(BASE + 32'hC, F3_W, 32'hDEAD_BEEF);
        bus_read(BASE + 32'hC, rd, hit);
        check("millis_ro", rd, 32'd1);

        // Mid-period duty change: period starts at edge 12288; write lands at cnt 100.
        wait_cyc(12010);
        bus_write(BASE, F3_W, 32'h0000_0010);
        wait_cyc(12300);
        check("led_d16_cnt11", 32'(LED), 32'h1);
        wait_cyc(12310);
        check("led_d16_cnt21", 32'(LED), 32'h0);
        wait_cyc(12388);
        bus_write(BASE, F3_W, 32'h0000_00F0);
        wait_cyc(12400);
        check("mid_write_no_glitch", 32'(LED), 32'h0);
        wait_cyc(12544);
        check("mid_write_cnt255", 32'(LED), 32'h0);
        wait_cyc(12545);
        check("new_duty_cnt0", 32'(LED), 32'h1);
        wait_cyc(12745);
        check("new_duty_cnt200", 32'(pins), 32'b1000);
        wait_cyc(12785);
        check("new_duty_cnt240", 32'(LED), 32'h0);

        // Prescale 3: each count lasts 4 clk, period 1024 clk.
        wait_cyc(12800);
        bus_write(BASE, F3_W, 32'h0000_0080);
        bus_write(BASE + 32'h4, F3_W, 32'h0000_0301);
        bus_read(BASE + 32'h4, rd, hit);
        check("ctrl_readback", rd, 32'h0000_0301);
        wait_cyc(15000);
        count_high(1024, c_led, c_r, c_g, c_b);
        check("pre3_led_512", c_led, 512);
        check("pre3_rgb_0", c_r + c_g + c_b, 0);
        wait_led(1'b0, 2048, waited);
        check("wait_led_low", 32'(LED), 32'h0);
        wait_led(1'b1, 2048, waited);
        check("wait_led_rise", 32'(LED), 32'h1);
        wait_led(1'b0, 2048, hi_len);
        check("pre3_high_len", hi_len, 512);
        wait_led(1'b1, 2048, lo_len);
        check("pre3_low_len", lo_len, 512);

        // Disable: pins low one edge after the write edge; counters keep going.
        bus_write(BASE + 32'h4, F3_W, 32'h0);
        @(negedge clk);
        check("disable_pins_low", 32'(pins), 32'h0);
        repeat (600) @(negedge clk);
        check("disable_stays_low", 32'(pins), 32'h0);
        snap = cyc;
        bus_read(BASE + 32'h8, rd, hit);
        check("micros_running", rd, 32'(snap / 12));

        // Async reset mid-period with LED high at pwm_cnt 200.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_write(BASE, F3_W, 32'h0000_00FF);
        bus_read(BASE, rd, hit);
        check("pre_reset_duty", rd, 32'h0000_00FF);
        wait_cyc(457);
        check("led_high_cnt200", 32'(LED), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_led", 32'(pins), 32'h0);
        check("async_rdata", mem_rdata, 32'h0);
        check("async_hit", 32'(mem_hit), 32'h0);
        check("async_micros", dut.micros, 32'h0);
        check("async_duty", dut.duty, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_read(BASE, rd, hit);
        check("post_reset_duty", rd, 32'h0);
        bus_write(BASE, F3_W, 32'h0000_00FF);
        wait_cyc(256);
        check("post_reset_shadow0", 32'(LED), 32'h0);
        wait_cyc(257);
        check("post_reset_first_wrap", 32'(LED), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
